serial_addsub_ctrl: RTL



---
 rtl/serial_addsub_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl
//
// Bit-serial adder/subtractor. A single 1-bit full-adder slice is reused
// over WIDTH cycles, LSB first, with the carry held in a flop between
// cycles. Operands are taken on a valid/ready input handshake. The result
// is offered on a valid/ready output handshake.
//
// Optional feature: define SERIAL_ADDSUB_OVF_EN to add the Ovf output
// (signed two's-complement overflow). Without the macro the port and its
// flop are absent.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A, B and Sub are valid this cycle
//   in_ready   block can accept operands (high only while idle)
//   A, B       WIDTH-bit operands, sampled on accept
//   Sub        0 = A+B, 1 = A-B, sampled on accept
//   out_valid  Sum/Cout (and Ovf) are valid
//   out_ready  consumer takes the result
//   Sum        WIDTH-bit result, modulo 2^WIDTH
//   Cout       carry out of the MSB; for subtraction 1 means no borrow
//   Busy       an operation is running or its result is waiting
//   Ovf        (SERIAL_ADDSUB_OVF_EN only) signed overflow
// ---------------------------------------------------------------------------
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Busy
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_bit;
    logic             last_bit;

    // The single full-adder slice. It always looks at the current LSBs of
    // the operand shift registers and the held carry.
    always_comb begin
        s_bit    = opa[0] ^ opb[0] ^ carry;
        c_bit    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Controller and datapath. Subtraction is A + ~B + 1: B is inverted
    // on load and the carry flop starts at 1. Result bits enter at the MSB
    // of the result register, so after WIDTH shifts the first bit computed
    // sits at bit 0. The handshake outputs are registered along with the
    // state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            Busy      <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            Ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa      <= A;
                        opb      <= B ^ {WIDTH{Sub}};
                        carry    <= Sub;
                        cnt      <= '0;
                        res      <= '0;
                        in_ready <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    res   <= {s_bit, res[WIDTH-1:1]};
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= c_bit;
                    if (last_bit) begin
                        // The carry flop still holds the carry into the
                        // MSB here, so overflow is that XOR the carry out.
                        Sum       <= {s_bit, res[WIDTH-1:1]};
                        Cout      <= c_bit;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
                        Ovf       <= carry ^ c_bit;
`endif
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        Busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
